// File: rtl/execution_sequencer.sv
// Front-panel sequencer: single-step, divided free-run and halt control of the datapath with
// interrupt vectoring. Optional PC breakpoint stop is built when SEQ_BREAKPOINT_EN is defined.
module execution_sequencer #(
    parameter int          RUN_DIV    = 4,
    parameter logic [31:0] IRQ_VECTOR = 32'h0000_0040
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic        irq,
    input  logic [31:0] pc,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    output logic        cpu_en,
    output logic        vec_sel,
    output logic        irq_ack,
    output logic        halted,
    output logic [1:0]  state,
    output logic [15:0] instr_count
);

    localparam int               CNT_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             step_q, step_d;
    logic             irq_q, irq_d;
    logic             pending_q, pending_d;
    logic             cpu_en_q, cpu_en_d;
    logic             vec_sel_q, vec_sel_d;
    logic             irq_ack_q, irq_ack_d;
    logic             halted_q, halted_d;
    logic [15:0]      instr_count_q, instr_count_d;

    logic step_edge;
    logic irq_edge;
    logic div_last;
    logic bp_hit;
    logic issue;

`ifdef SEQ_BREAKPOINT_EN
    assign bp_hit = bp_en && (pc == bp_addr);
`else
    logic unused_bp_inputs;
    assign bp_hit           = 1'b0;
    assign unused_bp_inputs = bp_en ^ (^bp_addr) ^ (^pc);
`endif

    // The datapath owns the vector mux; this block only tells it when to use it.
    logic unused_irq_vector;
    assign unused_irq_vector = ^IRQ_VECTOR;

    assign step_edge = step_btn & ~step_q;
    assign irq_edge  = irq & ~irq_q;
    assign div_last  = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        issue     = 1'b0;

        case (state_q)
            ST_HALT: begin
                if (run_sw) begin
                    state_d   = ST_RUN;
                    div_cnt_d = '0;
                end else if (step_edge) begin
                    issue = 1'b1;
                end
            end
            ST_RUN: begin
                // Dropping run_sw beats a terminal count; a breakpoint beats the strobe.
                if (!run_sw) begin
                    state_d = ST_HALT;
                end else if (div_last) begin
                    div_cnt_d = '0;
                    if (bp_hit) begin
                        state_d = ST_BREAK;
                    end else begin
                        issue = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                if (!run_sw) begin
                    state_d = ST_HALT;
                end else if (step_edge) begin
                    issue     = 1'b1;
                    state_d   = ST_RUN;
                    div_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_HALT;
                div_cnt_d = '0;
            end
        endcase

        step_d        = step_btn;
        irq_d         = irq;
        cpu_en_d      = issue;
        vec_sel_d     = issue & pending_q;
        irq_ack_d     = issue & pending_q;
        // An edge arriving while the old request is being acked queues a fresh one.
        pending_d     = irq_edge | (pending_q & ~issue);
        instr_count_d = instr_count_q + {15'd0, issue};
        halted_d      = (state_d != ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_HALT;
            div_cnt_q     <= '0;
            step_q        <= 1'b1;
            irq_q         <= 1'b1;
            pending_q     <= 1'b0;
            cpu_en_q      <= 1'b0;
            vec_sel_q     <= 1'b0;
            irq_ack_q     <= 1'b0;
            halted_q      <= 1'b1;
            instr_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            div_cnt_q     <= div_cnt_d;
            step_q        <= step_d;
            irq_q         <= irq_d;
            pending_q     <= pending_d;
            cpu_en_q      <= cpu_en_d;
            vec_sel_q     <= vec_sel_d;
            irq_ack_q     <= irq_ack_d;
            halted_q      <= halted_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cpu_en      = cpu_en_q;
    assign vec_sel     = vec_sel_q;
    assign irq_ack     = irq_ack_q;
    assign halted      = halted_q;
    assign state       = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_execution_sequencer.sv
// Self-checking bench for execution_sequencer: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the sequencing rules.
module tb_execution_sequencer;

    localparam int          RUN_DIV    = 4;
    localparam logic [31:0] IRQ_VECTOR = 32'h0000_0040;
`ifdef SEQ_BREAKPOINT_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        step_btn = 1'b0;
    logic        run_sw = 1'b0;
    logic        irq = 1'b0;
    logic [31:0] pc = 32'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic        cpu_en, vec_sel, irq_ack, halted;
    logic [1:0]  state;
    logic [15:0] instr_count;

    logic        step_btn_w = 1'b0;
    logic        run_sw_w = 1'b0;
    logic        irq_w = 1'b0;
    logic [31:0] pc_w = 32'd0;
    logic        bp_en_w = 1'b0;
    logic [31:0] bp_addr_w = 32'd0;
    logic        cpu_en_w, vec_sel_w, irq_ack_w, halted_w;
    logic [1:0]  state_w;
    logic [15:0] instr_count_w;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0=halt 1=run 2=break, phase counts cycles spent in run
    int m_state = 0;
    int m_phase = 0;
    int m_count = 0;
    bit m_pending = 1'b0;
    bit m_prev_step = 1'b1;
    bit m_prev_irq = 1'b1;
    bit e_cpu_en = 1'b0;
    bit e_vec = 1'b0;

    execution_sequencer #(.RUN_DIV(RUN_DIV), .IRQ_VECTOR(IRQ_VECTOR)) dut (
        .clock(clock), .reset(reset), .step_btn(step_btn), .run_sw(run_sw), .irq(irq),
        .pc(pc), .bp_en(bp_en), .bp_addr(bp_addr), .cpu_en(cpu_en), .vec_sel(vec_sel),
        .irq_ack(irq_ack), .halted(halted), .state(state), .instr_count(instr_count)
    );

    execution_sequencer #(.RUN_DIV(1), .IRQ_VECTOR(IRQ_VECTOR)) dut_w (
        .clock(clock), .reset(reset), .step_btn(step_btn_w), .run_sw(run_sw_w), .irq(irq_w),
        .pc(pc_w), .bp_en(bp_en_w), .bp_addr(bp_addr_w), .cpu_en(cpu_en_w), .vec_sel(vec_sel_w),
        .irq_ack(irq_ack_w), .halted(halted_w), .state(state_w), .instr_count(instr_count_w)
    );

    always #5 clock = ~clock;

    // Advances the model over the upcoming edge using the inputs now applied, then steps the clock.
    task automatic tick();
        bit go;
        bit s_rise;
        bit i_rise;
        int nxt;
        if (reset) begin
            m_state = 0; m_phase = 0; m_count = 0; m_pending = 1'b0;
            m_prev_step = 1'b1; m_prev_irq = 1'b1; e_cpu_en = 1'b0; e_vec = 1'b0;
        end else begin
            s_rise = step_btn && !m_prev_step;
            i_rise = irq && !m_prev_irq;
            go = 1'b0;
            nxt = m_state;
            if (m_state == 0) begin
                if (run_sw) begin
                    nxt = 1; m_phase = 0;
                end else if (s_rise) begin
                    go = 1'b1;
                end
            end else if (m_state == 1) begin
                if (!run_sw) begin
                    nxt = 0;
                end else begin
                    if (m_phase % RUN_DIV == RUN_DIV - 1) begin
                        if (BP_ON && bp_en && pc == bp_addr) nxt = 2;
                        else go = 1'b1;
                    end
                    m_phase++;
                end
            end else begin
                if (!run_sw) begin
                    nxt = 0;
                end else if (s_rise) begin
                    go = 1'b1; nxt = 1; m_phase = 0;
                end
            end
            e_cpu_en = go;
            e_vec = go && m_pending;
            m_pending = i_rise || (m_pending && !go);
            if (go) m_count = (m_count + 1) % 65536;
            m_state = nxt;
            m_prev_step = step_btn;
            m_prev_irq = irq;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; step_btn = 1'b1; irq = 1'b1; run_sw = 1'b0;
        tick(); tick(); tick();
        total++;
        if ({state, halted, instr_count, cpu_en, irq_ack} !== {2'd0, 1'b1, 16'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL reset_values: state=%0d halted=%b count=%0d en=%b ack=%b, want 0 1 0 0 0",
                     state, halted, instr_count, cpu_en, irq_ack);
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (cpu_en !== 1'b0 || irq_ack !== 1'b0 || state !== 2'd0 || instr_count !== 16'd0) begin
                bad++;
                $display("[TB] FAIL reset_release_c%0d: en=%b ack=%b state=%0d count=%0d, want 0 0 0 0",
                         c, cpu_en, irq_ack, state, instr_count);
            end
        end
    endtask

    task automatic test_step();
        int pulses = 0;
        int hold;
        step_btn = 1'b0; irq = 1'b0;
        tick(); tick();
        for (int p = 0; p < 3; p++) begin
            hold = $urandom_range(1, 3);
            for (int c = 0; c < 5; c++) begin
                step_btn = (c < hold);
                tick();
                if (cpu_en) pulses++;
                total++;
                if (cpu_en !== (c == 0)) begin
                    bad++;
                    $display("[TB] FAIL step_pulse_p%0d_c%0d: en=%b, want %b", p, c, cpu_en, (c == 0));
                end
                total++;
                if ({cpu_en, vec_sel, irq_ack, halted, state, instr_count} !==
                    {e_cpu_en, e_vec, e_vec, (m_state != 1), 2'(m_state), 16'(m_count)}) begin
                    bad++;
                    $display("[TB] FAIL step_model_p%0d_c%0d: en=%b vec=%b state=%0d count=%0d, want en=%b vec=%b state=%0d count=%0d",
                             p, c, cpu_en, vec_sel, state, instr_count, e_cpu_en, e_vec, m_state, m_count);
                end
            end
        end
        total++;
        if (pulses != 3 || instr_count !== 16'd3) begin
            bad++;
            $display("[TB] FAIL step_total: pulses=%0d count=%0d, want 3 3", pulses, instr_count);
        end
    endtask

    task automatic test_run();
        int strobes = 0;
        run_sw = 1'b1;
        tick();
        for (int c = 0; c < 22; c++) begin
            if (cpu_en) strobes++;
            total++;
            if (cpu_en !== (c > 0 && c % RUN_DIV == 0)) begin
                bad++;
                $display("[TB] FAIL run_cadence_c%0d: en=%b, want %b", c, cpu_en, (c > 0 && c % RUN_DIV == 0));
            end
            total++;
            if ({cpu_en, vec_sel, irq_ack, halted, state, instr_count} !==
                {e_cpu_en, e_vec, e_vec, (m_state != 1), 2'(m_state), 16'(m_count)}) begin
                bad++;
                $display("[TB] FAIL run_model_c%0d: en=%b state=%0d count=%0d, want en=%b state=%0d count=%0d",
                         c, cpu_en, state, instr_count, e_cpu_en, m_state, m_count);
            end
            if (c == 9) step_btn = 1'b1;
            if (c == 11) step_btn = 1'b0;
            if (c == 21) run_sw = 1'b0;
            tick();
        end
        total++;
        if (strobes != 5 || state !== 2'd0 || halted !== 1'b1 || cpu_en !== 1'b0) begin
            bad++;
            $display("[TB] FAIL run_stop: strobes=%0d state=%0d halted=%b en=%b, want 5 0 1 0",
                     strobes, state, halted, cpu_en);
        end
    endtask

    task automatic test_irq();
        logic [15:0] irq_tab  = 16'b0000_1001_0000_0011;
        logic [15:0] step_tab = 16'b0010_0100_0100_1000;
        logic [15:0] en_tab   = 16'b0010_0100_0100_1000;
        logic [15:0] vec_tab  = 16'b0010_0100_0000_1000;
        for (int i = 0; i < 16; i++) begin
            irq = irq_tab[i];
            step_btn = step_tab[i];
            tick();
            total++;
            if ({cpu_en, vec_sel, irq_ack} !== {en_tab[i], vec_tab[i], vec_tab[i]}) begin
                bad++;
                $display("[TB] FAIL irq_table_i%0d: en=%b vec=%b ack=%b, want %b %b %b",
                         i, cpu_en, vec_sel, irq_ack, en_tab[i], vec_tab[i], vec_tab[i]);
            end
            total++;
            if ({cpu_en, vec_sel, irq_ack, halted, state, instr_count} !==
                {e_cpu_en, e_vec, e_vec, (m_state != 1), 2'(m_state), 16'(m_count)}) begin
                bad++;
                $display("[TB] FAIL irq_model_i%0d: en=%b vec=%b count=%0d, want en=%b vec=%b count=%0d",
                         i, cpu_en, vec_sel, instr_count, e_cpu_en, e_vec, m_count);
            end
        end
        irq = 1'b0; step_btn = 1'b0;
        tick();
    endtask

    task automatic test_breakpoint();
        int strobes = 0;
        bit saw_break = 1'b0;
        bit done = 1'b0;
        bp_en = 1'b1; bp_addr = 32'h0000_000C; pc = 32'd0; run_sw = 1'b1;
        tick();
        for (int c = 0; c < 60 && !done; c++) begin
            total++;
            if ({cpu_en, vec_sel, irq_ack, halted, state, instr_count} !==
                {e_cpu_en, e_vec, e_vec, (m_state != 1), 2'(m_state), 16'(m_count)}) begin
                bad++;
                $display("[TB] FAIL bp_model_c%0d: en=%b state=%0d count=%0d, want en=%b state=%0d count=%0d",
                         c, cpu_en, state, instr_count, e_cpu_en, m_state, m_count);
            end
            if (cpu_en) begin
                strobes++;
                pc = pc + 32'd4;
            end
            if (state == 2'd2) saw_break = 1'b1;
`ifdef SEQ_BREAKPOINT_EN
            done = saw_break;
`else
            done = (strobes == 4);
`endif
            if (!done) tick();
        end
        total++;
        if (!done) begin
            bad++;
            $display("[TB] FAIL bp_timeout: strobes=%0d state=%0d, want the run to finish within 60 cycles",
                     strobes, state);
        end
`ifdef SEQ_BREAKPOINT_EN
        total++;
        if (state !== 2'd2 || strobes != 3 || cpu_en !== 1'b0 || halted !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_stop: state=%0d strobes=%0d en=%b halted=%b, want 2 3 0 1",
                     state, strobes, cpu_en, halted);
        end
        step_btn = 1'b1;
        tick();
        total++;
        if (cpu_en !== 1'b1 || state !== 2'd1 || halted !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_step_over: en=%b state=%0d halted=%b, want 1 1 0", cpu_en, state, halted);
        end
        step_btn = 1'b0;
        pc = pc + 32'd4;
`else
        total++;
        if (saw_break || strobes != 4 || pc !== 32'h0000_0010) begin
            bad++;
            $display("[TB] FAIL bp_disabled: saw_break=%b strobes=%0d pc=%h, want 0 4 00000010",
                     saw_break, strobes, pc);
        end
`endif
        run_sw = 1'b0; bp_en = 1'b0;
        tick(); tick();
    endtask

    task automatic test_midrun_reset();
        run_sw = 1'b1; irq = 1'b1;
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        total++;
        if ({cpu_en, vec_sel, irq_ack, halted, state, instr_count} !== {1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'd0}) begin
            bad++;
            $display("[TB] FAIL midrun_reset: en=%b vec=%b ack=%b halted=%b state=%0d count=%0d, want 0 0 0 1 0 0",
                     cpu_en, vec_sel, irq_ack, halted, state, instr_count);
        end
        reset = 1'b0; run_sw = 1'b0; irq = 1'b0;
        tick(); tick();
        step_btn = 1'b1;
        tick();
        total++;
        if (cpu_en !== 1'b1 || vec_sel !== 1'b0 || irq_ack !== 1'b0 || instr_count !== 16'd1) begin
            bad++;
            $display("[TB] FAIL midrun_pending_dropped: en=%b vec=%b ack=%b count=%0d, want 1 0 0 1",
                     cpu_en, vec_sel, irq_ack, instr_count);
        end
        step_btn = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] pcs [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        bp_addr = 32'h0000_000C;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) run_sw = ~run_sw;
            step_btn = ($urandom_range(0, 3) == 0);
            irq = ($urandom_range(0, 7) == 0);
            bp_en = ($urandom_range(0, 3) != 0);
            tick();
            if (cpu_en) pc = pcs[$urandom_range(0, 3)];
            total++;
            if ({cpu_en, vec_sel, irq_ack, halted, state, instr_count} !==
                {e_cpu_en, e_vec, e_vec, (m_state != 1), 2'(m_state), 16'(m_count)}) begin
                bad++;
                $display("[TB] FAIL random_c%0d: en=%b vec=%b ack=%b halted=%b state=%0d count=%0d, want en=%b vec=%b halted=%b state=%0d count=%0d",
                         c, cpu_en, vec_sel, irq_ack, halted, state, instr_count,
                         e_cpu_en, e_vec, (m_state != 1), m_state, m_count);
            end
        end
        reset = 1'b0; run_sw = 1'b0; step_btn = 1'b0; irq = 1'b0; bp_en = 1'b0;
        tick(); tick();
    endtask

    task automatic test_wrap();
        int n = 0;
        int gaps = 0;
        bit first = 1'b0;
        run_sw_w = 1'b1;
        tick();
        for (int c = 0; c < 70000 && n < 65535; c++) begin
            if (cpu_en_w) begin
                n++;
                first = 1'b1;
            end else if (first) begin
                gaps++;
            end
            if (n < 65535) tick();
        end
        total++;
        if (n != 65535) begin
            bad++;
            $display("[TB] FAIL wrap_timeout: strobes=%0d, want 65535", n);
        end
        total++;
        if (instr_count_w !== 16'hFFFF || gaps != 0) begin
            bad++;
            $display("[TB] FAIL wrap_preload: count=%0d gaps=%0d, want 65535 0", instr_count_w, gaps);
        end
        tick();
        total++;
        if (cpu_en_w !== 1'b1 || instr_count_w !== 16'd0) begin
            bad++;
            $display("[TB] FAIL wrap_rollover: en=%b count=%0d, want 1 0", cpu_en_w, instr_count_w);
        end
        run_sw_w = 1'b0;
        tick(); tick();
        total++;
        if (halted_w !== 1'b1 || cpu_en_w !== 1'b0 || state_w !== 2'd0) begin
            bad++;
            $display("[TB] FAIL wrap_halt: halted=%b en=%b state=%0d, want 1 0 0", halted_w, cpu_en_w, state_w);
        end
    endtask

    initial begin
        $display("[TB] execution_sequencer bench start, breakpoint feature=%0d", BP_ON);
        test_reset();
        test_step();
        test_run();
        test_irq();
        test_breakpoint();
        test_midrun_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execution_sequencer.md
# execution_sequencer

Sequencer that decides when the single-cycle MIPS datapath advances by one instruction. It sits between the debounced front-panel inputs and the datapath, and produces a one-cycle `cpu_en` strobe in three cases: manual single-step, free-running at a divided rate, or never while halted. It also stops at a PC breakpoint and steers the PC to a fixed interrupt vector when an external interrupt is taken.

## Interface
Parameters:
- `RUN_DIV`, default 4: clock cycles between instruction strobes in RUN; legal range ≥ 1.
- `IRQ_VECTOR`, default 32'h0000_0040: PC value the datapath loads when an interrupt is taken.

Ports:
- `clock`  in  1: single system clock; every flop is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `step_btn`  in  1: debounced step button, level.
- `run_sw`  in  1: 1 = free-run requested, 0 = halt requested.
- `irq`  in  1: interrupt request, level; the rising edge is what counts.
- `pc`  in  32: current datapath PC; stable between strobes.
- `bp_en`  in  1: breakpoint enable.
- `bp_addr`  in  32: breakpoint PC.
- `cpu_en`  out  1: one-cycle strobe; the datapath commits exactly one instruction per strobe.
- `vec_sel`  out  1: when high together with `cpu_en`, the PC loads `IRQ_VECTOR` instead of next-PC.
- `irq_ack`  out  1: one-cycle pulse, coincident with the vectoring strobe.
- `halted`  out  1: 1 when state ≠ RUN.
- `state`  out  2: HALT=0, RUN=1, BREAK=2.
- `instr_count`  out  16: number of strobes issued; wraps at 65535 → 0.

## Operation
- Step edge: `step_q` holds the registered `step_btn`. An edge is `step_btn & ~step_q`.
- IRQ edge: `irq_q` holds the registered `irq`. An edge sets `pending`.
- Issue (one cycle), in the cycle after the issue decision:
  - `cpu_en` = 1 and `instr_count` += 1.
  - If `pending`: `vec_sel` = 1, `irq_ack` = 1, and `pending` clears.
  - A new IRQ edge in the same cycle as the ack leaves `pending` set.
- HALT:
  - A step edge issues one strobe; state stays HALT.
  - `run_sw` = 1 moves to RUN and clears `div_cnt`.
  - If a step edge and `run_sw` = 1 arrive in the same cycle, the step edge is ignored and the block enters RUN.
- RUN:
  - `div_cnt` counts 0 to RUN_DIV−1 and wraps.
  - At terminal count with `bp_en` = 1 and `pc == bp_addr`: no strobe, go to BREAK; `pending` is retained (breakpoint wins over interrupt).
  - At terminal count otherwise: issue a strobe.
  - `run_sw` = 0 moves to HALT with no strobe; this has priority over a terminal count in the same cycle.
  - Step edges are ignored.
- BREAK:
  - `run_sw` = 0 moves to HALT.
  - Otherwise a step edge issues one strobe and returns to RUN with `div_cnt` cleared; this steps over the breakpoint.
- Every path from a state back into RUN clears `div_cnt`.

## Timing
- Reset values:
  - state HALT; `halted` = 1.
  - `cpu_en`, `vec_sel`, `irq_ack` = 0; `instr_count` = 0; `div_cnt` = 0; `pending` = 0.
  - `step_q` and `irq_q` load 1, so a button or IRQ already high at reset release does not create an edge.
- Reset mid-RUN or mid-strobe: outputs return to reset values on the next edge. A pending interrupt is dropped.
- Step latency: `step_btn` rises before edge n, so the edge is detected at edge n and `cpu_en` is high for cycle n+1, one cycle wide.
- RUN cadence:
  - First strobe is high RUN_DIV cycles after the cycle in which state becomes RUN.
  - Thereafter one strobe every RUN_DIV cycles.
  - RUN_DIV = 1 gives `cpu_en` high every cycle.
- Breakpoint: the compare uses the `pc` value at terminal count; state reads BREAK in the following cycle.
- `instr_count` updates in the same cycle that `cpu_en` is high.
- All outputs are registered.

## Configuration
- `SEQ_BREAKPOINT_EN` defined: breakpoint compare and the BREAK state are present, as described above.
- `SEQ_BREAKPOINT_EN` not defined:
  - `bp_en` and `bp_addr` are ignored and BREAK is unreachable.
  - `state` never reads 2.
  - RUN issues a strobe at every terminal count.

## Test plan
- Reset held with `step_btn` = 1 and `irq` = 1, then released:
  - Expect state 0, `halted` 1, `instr_count` 0.
  - Expect no `cpu_en` and no `irq_ack` for 10 cycles.
- HALT, three step presses spaced 5 cycles apart:
  - Expect exactly three `cpu_en` pulses, each one cycle wide and one cycle after its edge.
  - Expect `instr_count` = 3.
- RUN_DIV = 4, `run_sw` raised at cycle 0 and dropped at cycle 21:
  - Expect strobes at cycles 4, 8, 12, 16, 20 and state HALT at cycle 22.
  - A step press during RUN produces no extra strobe.
- Breakpoint, RUN with `bp_en` = 1, `bp_addr` = 0x0C, `pc` driven 0x00, 0x04, 0x08, 0x0C on successive strobes:
  - Expect state 2 and no strobe at `pc` = 0x0C.
  - A step press then gives one strobe and state 1.
  - Without `SEQ_BREAKPOINT_EN`: expect no stop.
- IRQ edge in HALT, then a step press:
  - Expect that strobe to have `vec_sel` = 1 and `irq_ack` = 1.
  - The next step has `vec_sel` = 0.
  - A second IRQ edge on the ack cycle makes the following strobe vectored as well.
- `instr_count` preloaded to 65535 via 65535 strobes at RUN_DIV = 1: the next strobe wraps it to 0.
